// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/pause and clear keys drive an IDLE/RUN/PAUSE FSM and a tick prescaler.
// Latency: a held key changes running/paused DB_CYCLES+4 edges after the first low sample; tick is registered.
// Backpressure: none; the downstream counter must accept every tick and cnt_clear pulse.
module stopwatch_ctrl #(
    parameter int DIV       = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_start_n,
    input  logic key_clear_n,
    output logic tick,
    output logic cnt_clear,
    output logic running,
    output logic paused
);

    localparam int DIV_W = $clog2(DIV);
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Key index 0 is start/pause, index 1 is clear.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [1:0]      db_dly_q, db_dly_d;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic             cnt_clear_q, cnt_clear_d;

    logic start_ev;
    logic clear_ev;

    // Synchronize, debounce and edge-detect both keys.
    always_comb begin
        sync1_d  = {key_clear_n, key_start_n};
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_dly_d = db_q;
        // A press is a falling edge of the debounced level; releases are ignored.
        press_d  = db_dly_q & ~db_q;
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            if (sync2_q[k] != db_q[k]) begin
                if (db_cnt_q[k] == DB_MAX) begin
                    db_d[k]     = sync2_q[k];
                    db_cnt_d[k] = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end else begin
                db_cnt_d[k] = '0;
            end
        end
    end

    // Key front-end registers; released (1) levels out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            db_q     <= 2'b11;
            db_dly_q <= 2'b11;
            press_q  <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            press_q  <= press_d;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
        end
    end

    assign start_ev = press_q[0];
    assign clear_ev = press_q[1];

    // Next-state, prescaler and output pulses; clear overrides start and any coincident wrap.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        tick_d      = 1'b0;
        cnt_clear_d = clear_ev;
        if (clear_ev) begin
            state_d   = S_IDLE;
            div_cnt_d = '0;
        end else begin
            // Prescaler only moves in RUN, so a pause keeps the tick phase.
            if (state_q == S_RUN) begin
                if (div_cnt_q == DIV_MAX) begin
                    div_cnt_d = '0;
                    tick_d    = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            if (start_ev) begin
                case (state_q)
                    S_IDLE:  state_d = S_RUN;
                    S_RUN:   state_d = S_PAUSE;
                    S_PAUSE: state_d = S_RUN;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // FSM state, prescaler and registered pulse outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            tick_q      <= 1'b0;
            cnt_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            tick_q      <= tick_d;
            cnt_clear_q <= cnt_clear_d;
        end
    end

    assign tick      = tick_q;
    assign cnt_clear = cnt_clear_q;
    assign running   = (state_q == S_RUN);
    assign paused    = (state_q == S_PAUSE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with DIV=5, DB_CYCLES=4.
// Directed scenarios plus random key activity checked against a behavioural model.
// Inputs are driven at the falling edge; outputs are checked at the falling edge.
module tb_stopwatch_ctrl;

    localparam int DIV = 5;
    localparam int DB  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic clock = 1'b0;
    logic reset;
    logic key_start_n;
    logic key_clear_n;
    logic tick;
    logic cnt_clear;
    logic running;
    logic paused;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: raw key sample history (bit k = sample k edges ago), accepted levels, FSM and tick phase.
    logic [31:0] m_hs, m_hc;
    logic        m_acc_s, m_acc_c;
    int          m_state;
    int          m_phase;
    logic        m_tick, m_clr;

    stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
        .tick        (tick),
        .cnt_clear   (cnt_clear),
        .running     (running),
        .paused      (paused)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // A level is accepted once DB+1 consecutive raw samples disagree with the current level;
    // the state effect lands 4 edges after the last of those samples.
    function automatic logic win_diff(input logic [31:0] h, input logic acc);
        for (int i = 4; i <= DB + 4; i++) begin
            if (h[i] == acc) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input logic ks, input logic kc, input logic rst);
        logic sev, cev;
        if (!rst) begin
            m_hs    = '1;
            m_hc    = '1;
            m_acc_s = 1'b1;
            m_acc_c = 1'b1;
            m_state = M_IDLE;
            m_phase = 0;
            m_tick  = 1'b0;
            m_clr   = 1'b0;
            return;
        end
        m_hs = {m_hs[30:0], ks};
        m_hc = {m_hc[30:0], kc};
        sev  = 1'b0;
        cev  = 1'b0;
        if (win_diff(m_hs, m_acc_s)) begin
            m_acc_s = ~m_acc_s;
            sev     = ~m_acc_s;
        end
        if (win_diff(m_hc, m_acc_c)) begin
            m_acc_c = ~m_acc_c;
            cev     = ~m_acc_c;
        end
        m_clr  = cev;
        m_tick = 1'b0;
        if (cev) begin
            m_state = M_IDLE;
            m_phase = 0;
        end else begin
            if (m_state == M_RUN) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_tick  = 1'b1;
                end
            end
            if (sev) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
        end
    endtask

    // One clock cycle: drive inputs, advance the model on the rising edge, compare on the falling edge.
    task automatic step(input logic ks, input logic kc, input logic rst);
        key_start_n = ks;
        key_clear_n = kc;
        reset       = rst;
        @(posedge clock);
        model_step(ks, kc, rst);
        @(negedge clock);
        chk("running",   int'(running),   int'(m_state == M_RUN));
        chk("paused",    int'(paused),    int'(m_state == M_PAUSE));
        chk("tick",      int'(tick),      int'(m_tick));
        chk("cnt_clear", int'(cnt_clear), int'(m_clr));
        cyc++;
    endtask

    task automatic press_start(input int low_cycles, input int high_cycles);
        for (int i = 0; i < low_cycles; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < high_cycles; i++) step(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int cnt;
        int rem_s, rem_c;
        logic ks, kc, rs;

        reset       = 1'b0;
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        m_hs = '1; m_hc = '1; m_acc_s = 1'b1; m_acc_c = 1'b1;
        m_state = M_IDLE; m_phase = 0; m_tick = 1'b0; m_clr = 1'b0;

        // Reset state.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_outputs", int'({tick, cnt_clear, running, paused}), 0);

        // Bouncing start key: toggles every 2 cycles, never stable long enough.
        for (int i = 0; i < 40; i++) begin
            step(((i / 2) % 2) == 1, 1'b1, 1'b1);
            chk("bounce_run",  int'(running), 0);
            chk("bounce_tick", int'(tick),    0);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);

        // Start held from edge 0: RUN after edge 8, ticks after edges 13, 18, 23.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 26; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("start_run",  int'(running), int'(i >= 8));
            chk("start_tick", int'(tick),    int'(i == 13 || i == 18 || i == 23));
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1);

        // Second press pauses with no ticks; third resumes with the old phase.
        press_start(10, 10);
        chk("pause_state", int'(paused), 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1);
            cnt += int'(tick);
        end
        chk("pause_ticks", cnt, 0);
        press_start(10, 20);
        chk("resume_state", int'(running), 1);

        // Back to PAUSE, then start and clear together: clear wins with one cnt_clear.
        press_start(10, 12);
        chk("pause2_state", int'(paused), 1);
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            step(i >= 10, i >= 10, 1'b1);
            cnt += int'(cnt_clear);
        end
        chk("both_clr_pulses", cnt, 1);
        chk("both_idle", int'({running, paused}), 0);

        // Clear event lands on the prescaler wrap edge (edge 18): tick suppressed.
        for (int i = 0; i < 30; i++) begin
            step(!(i < 12), !(i >= 10 && i < 24), 1'b1);
            if (i == 13) chk("wrap_tick13", int'(tick), 1);
            if (i == 18) begin
                chk("wrap_tick18", int'(tick), 0);
                chk("wrap_clr18",  int'(cnt_clear), 1);
            end
            if (i == 19) chk("wrap_clr19", int'(cnt_clear), 0);
            if (i >= 19) chk("wrap_idle", int'(running), 0);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1);

        // Reset pulse mid-RUN with start held: everything aborts, stays IDLE until re-pressed.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
        chk("rr_running", int'(running), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("rr_outputs", int'({tick, cnt_clear, running, paused}), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("rr_idle", int'({running, paused}), 0);
        end
        press_start(10, 10);
        chk("rr_repress", int'(running), 1);

        // Random key activity with occasional resets.
        ks = 1'b1; kc = 1'b1; rem_s = 0; rem_c = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rem_s == 0) begin
                ks    = 1'($urandom_range(0, 1));
                rem_s = $urandom_range(1, 12);
            end
            if (rem_c == 0) begin
                kc    = ($urandom_range(0, 3) != 0);
                rem_c = $urandom_range(1, 12);
            end
            rs = ($urandom_range(0, 399) != 0);
            step(ks, kc, rs);
            rem_s--;
            rem_c--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 50000000: clock cycles per tick; DIV >= 2.
REQ-002 Parameter DB_CYCLES, default 1000000: consecutive stable cycles needed to accept a key level; DB_CYCLES >= 1.
REQ-003 clock  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 key_start_n  input  1  raw start/pause pushbutton, active-low, asynchronous, may bounce.
REQ-006 key_clear_n  input  1  raw clear pushbutton, active-low, asynchronous, may bounce.
REQ-007 tick  output  1  one-cycle count-enable pulse to the downstream counter.
REQ-008 cnt_clear  output  1  one-cycle clear pulse to the downstream counter.
REQ-009 running  output  1  high while the FSM is in RUN.
REQ-010 paused  output  1  high while the FSM is in PAUSE.

Function
REQ-011 Each key SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-012 Per key debouncer: a counter increments while the synchronized level differs from the debounced level, resets to 0 on any match, and the debounced level takes the synchronized value when the counter reaches DB_CYCLES.
REQ-013 A 1->0 transition of a debounced level SHALL produce a registered one-cycle press event; 0->1 transitions produce nothing.
REQ-014 FSM states IDLE, RUN, PAUSE; state register is the only source of running/paused (running = RUN, paused = PAUSE).
REQ-015 Transitions: IDLE + start -> RUN; RUN + start -> PAUSE; PAUSE + start -> RUN; clear in any state -> IDLE.
REQ-016 Simultaneous start and clear events: clear wins; next state IDLE.
REQ-017 Clear event SHALL register cnt_clear high for exactly one cycle, in every state including IDLE.
REQ-018 Prescaler div_cnt, width ceil(log2(DIV)), advances on every edge at which the current state is RUN; at DIV-1 it wraps to 0 and registers tick high for the next cycle.
REQ-019 tick SHALL be low in every cycle not following a wrap; tick period in continuous RUN is exactly DIV cycles.
REQ-020 In PAUSE div_cnt SHALL hold its value, so resuming preserves tick phase.
REQ-021 A clear event SHALL set div_cnt to 0 and force tick low on the same edge, overriding a coincident wrap.
REQ-022 Press-to-state latency: running (or paused) changes DB_CYCLES+4 rising edges after the first edge sampling the raw key low, provided the key stays low.
REQ-023 Key held low indefinitely SHALL produce exactly one press event; auto-repeat is forbidden.
REQ-024 Bounce pulses shorter than DB_CYCLES cycles SHALL produce no event.

Reset
REQ-025 While reset is low at a rising edge: state IDLE, div_cnt 0, debounce counters 0, synchronizer and debounced levels 1 (released), all press events 0.
REQ-026 Outputs after a reset edge: tick 0, cnt_clear 0, running 0, paused 0.
REQ-027 Reset asserted mid-RUN or mid-debounce SHALL abort all activity with no tick or cnt_clear pulse emitted; a key held through reset release SHALL require the full DB_CYCLES before generating an event.

Verification (DIV=5, DB_CYCLES=4)
REQ-028 Reset, then key_start_n low at edge 0 and held -> running 1 after edge 8; tick high after edges 13, 18, 23; exactly one press event.
REQ-029 In RUN, second start press -> paused 1, tick stays 0; third press -> running 1, first tick lands to preserve the prior phase (remaining div_cnt count).
REQ-030 key_start_n toggling every 2 cycles for 40 cycles -> no state change, tick 0.
REQ-031 Start and clear pressed on the same edge while in PAUSE -> IDLE, one cnt_clear pulse, div_cnt 0, running 0, paused 0.
REQ-032 Clear press timed so its event coincides with div_cnt wrap -> tick 0, cnt_clear 1 for one cycle.
REQ-033 Reset low for one edge during RUN with key_start_n held low -> all outputs 0, stays IDLE until key released and re-pressed.
